// File: rtl/perf_snapshot_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : perf_pkg
// Description : Shared types and constants for the performance snapshot CSR.
//               Holds the capture FSM state encoding, the word index of each
//               host-visible register and the bit layout of STATUS.
// Revision    : 1.0 - initial release
// ============================================================================
package perf_pkg;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DIVIDE = 2'd3
    } perf_state_e;

    // Register word indices on the read port
    localparam logic [3:0] PERF_REG_STATUS   = 4'd0;
    localparam logic [3:0] PERF_REG_LAST_CYC = 4'd1;
    localparam logic [3:0] PERF_REG_LAST_PIX = 4'd2;
    localparam logic [3:0] PERF_REG_RATIO    = 4'd3;
    localparam logic [3:0] PERF_REG_RUN_CNT  = 4'd4;
    localparam logic [3:0] PERF_REG_MAX_CYC  = 4'd5;
    localparam logic [3:0] PERF_REG_MIN_CYC  = 4'd6;

    // STATUS bit positions
    localparam int STATUS_SNAP_VALID_BIT = 0;
    localparam int STATUS_SAT_BIT        = 1;
    localparam int STATUS_BUSY_BIT       = 2;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Unsigned restoring divider, one quotient bit per clock.
//               A start pulse loads the operands; DIVIDEND_WIDTH cycles later
//               done pulses for one cycle with quotient/remainder stable.
//               abort drops an in-flight division without a done pulse.
// Ports       : clk, rst_n       - clock, async active-low reset
//               start, abort     - load operands / discard current division
//               dividend, divisor- operands (sampled on start)
//               busy, done       - iterating / one-cycle completion pulse
//               quotient, remainder - results, valid while done is high
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int DIVIDEND_WIDTH = 40,
    parameter int DIVISOR_WIDTH  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DIVIDEND_WIDTH-1:0] dividend,
    input  logic [DIVISOR_WIDTH-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [DIVIDEND_WIDTH-1:0] quotient,
    output logic [DIVISOR_WIDTH-1:0]  remainder
);

    localparam int CNT_W = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  r_rem;
    logic [DIVIDEND_WIDTH-1:0] r_quo;
    logic [DIVISOR_WIDTH-1:0]  r_dvs;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_busy;
    logic                      r_done;

    // The partial remainder is always below the divisor, so after the shift
    // it needs exactly one extra bit to be compared against the divisor.
    logic [DIVISOR_WIDTH:0]    w_shift;
    logic [DIVISOR_WIDTH:0]    w_diff;
    logic                      w_ge;

    assign w_shift = {r_rem, r_quo[DIVIDEND_WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift - {1'b0, r_dvs};

    // r_quo doubles as the dividend shift register: dividend bits leave at
    // the MSB while quotient bits enter at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (start) begin
            r_rem  <= '0;
            r_quo  <= dividend;
            r_dvs  <= divisor;
            r_cnt  <= CNT_W'(DIVIDEND_WIDTH);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[DIVISOR_WIDTH-1:0] : w_shift[DIVISOR_WIDTH-1:0];
            r_quo  <= {r_quo[DIVIDEND_WIDTH-2:0], w_ge};
            r_cnt  <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/perf_snapshot_csr.sv
`default_nettype none
// ============================================================================
// Module      : perf_snapshot_csr
// Description : Snapshots the final cycle/pixel counts of a measurement
//               window, computes pixels-per-cycle as unsigned fixed point,
//               keeps run statistics and serves them on a registered
//               word-addressed read port.
// Ports       : clk, rst_n          - clock, async active-low reset
//               start, done         - measurement window markers
//               perf_cyc, perf_pix  - live counters from the counter stage
//               clr_stats           - pulse, clear statistics and snapshot
//               rd_en, rd_addr      - read request and word index
//               rd_data, rd_valid   - read response, one cycle after rd_en
//               irq                 - one-cycle pulse on ratio commit
// Revision    : 1.0 - initial release
// ============================================================================
module perf_snapshot_csr
    import perf_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32,
    parameter int FRAC_BITS     = 8,
    parameter int RATIO_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     done,
    input  logic [COUNTER_WIDTH-1:0] perf_cyc,
    input  logic [COUNTER_WIDTH-1:0] perf_pix,
    input  logic                     clr_stats,
    input  logic                     rd_en,
    input  logic [3:0]               rd_addr,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic                     irq
);

    localparam int QUO_WIDTH = COUNTER_WIDTH + FRAC_BITS;

    function automatic logic [31:0] fit32_cnt(input logic [COUNTER_WIDTH-1:0] v);
        logic [COUNTER_WIDTH+31:0] ext;
        ext = {32'd0, v};
        return ext[31:0];
    endfunction

    function automatic logic [31:0] fit32_ratio(input logic [RATIO_WIDTH-1:0] v);
        logic [RATIO_WIDTH+31:0] ext;
        ext = {32'd0, v};
        return ext[31:0];
    endfunction

    perf_state_e              r_state;
    perf_state_e              w_next;

    logic                     r_done_q;
    logic                     r_zero_div;
    logic [COUNTER_WIDTH-1:0] r_last_cyc;
    logic [COUNTER_WIDTH-1:0] r_last_pix;
    logic [RATIO_WIDTH-1:0]   r_ratio;
    logic                     r_sat;
    logic                     r_snap_valid;
    logic [COUNTER_WIDTH-1:0] r_run_count;
    logic [COUNTER_WIDTH-1:0] r_max_cyc;
    logic [COUNTER_WIDTH-1:0] r_min_cyc;
    logic                     r_irq;
    logic [31:0]              r_rd_data;
    logic                     r_rd_valid;

    logic                     w_capture;
    logic                     w_commit;
    logic                     w_div_start;
    logic                     w_div_busy;
    logic                     w_div_done;
    logic [QUO_WIDTH-1:0]     w_div_quo;
    logic [COUNTER_WIDTH-1:0] w_div_rem;
    logic                     w_commit_sat;
    logic [RATIO_WIDTH-1:0]   w_commit_ratio;
    logic [COUNTER_WIDTH-1:0] w_cnt_base;
    logic [COUNTER_WIDTH-1:0] w_max_base;
    logic [COUNTER_WIDTH-1:0] w_min_base;
    logic [COUNTER_WIDTH-1:0] w_cnt_next;
    logic [COUNTER_WIDTH-1:0] w_max_next;
    logic [COUNTER_WIDTH-1:0] w_min_next;
    logic [31:0]              w_rd_mux;

    // A fresh start always wins: it suppresses the capture and the commit
    // of the window it interrupts.
    assign w_capture   = (r_state == ST_SETTLE) && !start;
    assign w_commit    = (r_state == ST_DIVIDE) && !start && (r_zero_div || w_div_done);
    assign w_div_start = w_capture && (perf_cyc != '0);

    // The divider takes its operands straight from the counters on the
    // capture edge so the first quotient bit is produced one cycle earlier.
    seq_divider #(
        .DIVIDEND_WIDTH (QUO_WIDTH),
        .DIVISOR_WIDTH  (COUNTER_WIDTH)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .abort     (start),
        .dividend  ({perf_pix, {FRAC_BITS{1'b0}}}),
        .divisor   (perf_cyc),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    assign w_commit_sat   = r_zero_div || ((w_div_quo >> RATIO_WIDTH) != '0);
    assign w_commit_ratio = w_commit_sat ? {RATIO_WIDTH{1'b1}} : w_div_quo[RATIO_WIDTH-1:0];

    // Statistics update on top of the post-clear values, so a clear landing
    // on the capture edge yields a single-run history.
    assign w_cnt_base = clr_stats ? '0 : r_run_count;
    assign w_max_base = clr_stats ? '0 : r_max_cyc;
    assign w_min_base = clr_stats ? {COUNTER_WIDTH{1'b1}} : r_min_cyc;
    assign w_cnt_next = (w_cnt_base == {COUNTER_WIDTH{1'b1}}) ? w_cnt_base
                                                               : w_cnt_base + COUNTER_WIDTH'(1);
    assign w_max_next = (perf_cyc > w_max_base) ? perf_cyc : w_max_base;
    assign w_min_next = (perf_cyc < w_min_base) ? perf_cyc : w_min_base;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE:   w_next = ST_IDLE;
                ST_RUN:    if (done && !r_done_q) w_next = ST_SETTLE;
                ST_SETTLE: w_next = ST_DIVIDE;
                ST_DIVIDE: if (w_commit) w_next = ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q     <= 1'b0;
            r_zero_div   <= 1'b0;
            r_last_cyc   <= '0;
            r_last_pix   <= '0;
            r_ratio      <= '0;
            r_sat        <= 1'b0;
            r_snap_valid <= 1'b0;
            r_run_count  <= '0;
            r_max_cyc    <= '0;
            r_min_cyc    <= {COUNTER_WIDTH{1'b1}};
            r_irq        <= 1'b0;
        end else begin
            r_done_q <= done;
            r_irq    <= w_commit;

            if (clr_stats) begin
                r_run_count  <= '0;
                r_max_cyc    <= '0;
                r_min_cyc    <= {COUNTER_WIDTH{1'b1}};
                r_snap_valid <= 1'b0;
                r_sat        <= 1'b0;
                r_last_cyc   <= '0;
                r_last_pix   <= '0;
                r_ratio      <= '0;
            end

            if (w_capture) begin
                r_last_cyc  <= perf_cyc;
                r_last_pix  <= perf_pix;
                r_zero_div  <= (perf_cyc == '0);
                r_run_count <= w_cnt_next;
                r_max_cyc   <= w_max_next;
                r_min_cyc   <= w_min_next;
            end

            if (w_commit) begin
                r_ratio      <= w_commit_ratio;
                r_sat        <= w_commit_sat;
                r_snap_valid <= 1'b1;
            end

            if (start) begin
                r_snap_valid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------- read port
    always_comb begin
        w_rd_mux = '0;
        case (rd_addr)
            PERF_REG_STATUS: begin
                w_rd_mux[STATUS_BUSY_BIT]       = (r_state != ST_IDLE);
                w_rd_mux[STATUS_SAT_BIT]        = r_sat;
                w_rd_mux[STATUS_SNAP_VALID_BIT] = r_snap_valid;
            end
            PERF_REG_LAST_CYC: w_rd_mux = fit32_cnt(r_last_cyc);
            PERF_REG_LAST_PIX: w_rd_mux = fit32_cnt(r_last_pix);
            PERF_REG_RATIO:    w_rd_mux = fit32_ratio(r_ratio);
            PERF_REG_RUN_CNT:  w_rd_mux = fit32_cnt(r_run_count);
            PERF_REG_MAX_CYC:  w_rd_mux = fit32_cnt(r_max_cyc);
            PERF_REG_MIN_CYC:  w_rd_mux = fit32_cnt(r_min_cyc);
            default:           w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_perf_snapshot_csr.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_snapshot_csr
// Description : Self-checking bench for perf_snapshot_csr. Drives measurement
//               windows with directed and random counter values and compares
//               every register against a behavioural model of the snapshot,
//               ratio and statistics rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_snapshot_csr;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic        done      = 1'b0;
    logic        clr_stats = 1'b0;
    logic        rd_en     = 1'b0;
    logic [3:0]  rd_addr   = 4'd0;
    logic [31:0] perf_cyc  = 32'd0;
    logic [31:0] perf_pix  = 32'd0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the host-visible state
    logic [31:0] m_last_cyc, m_last_pix, m_count, m_max, m_min;
    logic [15:0] m_ratio;
    logic        m_sat, m_snap, m_busy;

    perf_snapshot_csr dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .perf_cyc  (perf_cyc),
        .perf_pix  (perf_pix),
        .clr_stats (clr_stats),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
        end
    endtask

    // Throughput = floor(pix * 2^8 / cyc), saturating to 16 bits; bit 16 = sat
    function automatic logic [16:0] ref_ratio(input logic [31:0] cyc, input logic [31:0] pix);
        longint unsigned num;
        longint unsigned den;
        longint unsigned q;
        if (cyc == 32'd0) return {1'b1, 16'hFFFF};
        num = pix;
        num = num * 256;
        den = cyc;
        q   = num / den;
        if (q > 64'd65535) return {1'b1, 16'hFFFF};
        return {1'b0, q[15:0]};
    endfunction

    task automatic model_reset();
        m_last_cyc = 0; m_last_pix = 0; m_count = 0; m_max = 0;
        m_min = 32'hFFFF_FFFF; m_ratio = 0; m_sat = 0; m_snap = 0; m_busy = 0;
    endtask

    task automatic model_clear();
        m_count = 0; m_max = 0; m_min = 32'hFFFF_FFFF; m_snap = 0; m_sat = 0;
        m_last_cyc = 0; m_last_pix = 0; m_ratio = 0;
    endtask

    task automatic model_capture(input logic [31:0] cyc, input logic [31:0] pix);
        m_last_cyc = cyc;
        m_last_pix = pix;
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        if (cyc > m_max) m_max = cyc;
        if (cyc < m_min) m_min = cyc;
    endtask

    // Back-to-back reads of all 16 words against the model
    task automatic read_all(input string tag);
        logic [31:0] want [16];
        for (int a = 0; a < 16; a++) want[a] = 32'd0;
        want[0] = {29'd0, m_busy, m_sat, m_snap};
        want[1] = m_last_cyc;
        want[2] = m_last_pix;
        want[3] = {16'd0, m_ratio};
        want[4] = m_count;
        want[5] = m_max;
        want[6] = m_min;
        rd_en   = 1'b1;
        rd_addr = 4'd0;
        for (int a = 0; a < 16; a++) begin
            tick();
            check($sformatf("%s_valid%0d", tag, a), {31'd0, rd_valid}, 32'd1);
            check($sformatf("%s_reg%0d", tag, a), rd_data, want[a]);
            rd_addr = 4'(a + 1);
        end
        rd_en = 1'b0;
        tick();
        check({tag, "_valid_idle"}, {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start    = 1'b0;
        perf_cyc = 32'd0;
        perf_pix = 32'd0;
        m_busy   = 1'b1;
        m_snap   = 1'b0;
    endtask

    // Counters ramp for run_len cycles; done is raised with the final values.
    // Returns just after the edge that first samples done high.
    task automatic do_done(input logic [31:0] cyc, input logic [31:0] pix, input int run_len);
        longint unsigned t;
        for (int i = 1; i < run_len; i++) begin
            t = cyc; t = t * longint'(i) / longint'(run_len); perf_cyc = t[31:0];
            t = pix; t = t * longint'(i) / longint'(run_len); perf_pix = t[31:0];
            tick();
        end
        perf_cyc = cyc;
        perf_pix = pix;
        done     = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic finish_measure(input logic [31:0] cyc, input logic [31:0] pix,
                                  input bit clr, input string tag);
        int          lat;
        bit          seen;
        logic [15:0] old_ratio;
        logic [16:0] r;
        if (clr) begin
            clr_stats = 1'b1;
            model_clear();
        end
        model_capture(cyc, pix);
        old_ratio = m_ratio;
        rd_en   = 1'b1;
        rd_addr = 4'd3;
        lat  = 0;
        seen = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            tick();
            clr_stats = 1'b0;
            lat = k;
            if (irq === 1'b1) seen = 1'b1;
        end
        check({tag, "_irq_seen"}, {31'd0, seen}, 32'd1);
        check({tag, "_irq_latency"}, lat, (cyc == 32'd0) ? 32'd2 : 32'd42);
        check({tag, "_read_precommit"}, rd_data, {16'd0, old_ratio});
        r = ref_ratio(cyc, pix);
        m_ratio = r[15:0];
        m_sat   = r[16];
        m_snap  = 1'b1;
        m_busy  = 1'b0;
        tick();
        check({tag, "_irq_single"}, {31'd0, irq}, 32'd0);
        check({tag, "_read_postcommit"}, rd_data, {16'd0, m_ratio});
        rd_en = 1'b0;
    endtask

    task automatic run_measure(input logic [31:0] cyc, input logic [31:0] pix,
                               input int run_len, input bit clr, input string tag);
        start_run();
        do_done(cyc, pix, run_len);
        finish_measure(cyc, pix, clr, tag);
        read_all(tag);
    endtask

    initial begin
        bit          seen;
        logic [31:0] c, p;
        int          sel;
        bit          clr;

        // Reset state
        model_reset();
        #1;
        check("reset_rd_data", rd_data, 32'd0);
        check("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        read_all("reset");

        // Nominal 100 cycles / 200 pixels -> 2.0
        run_measure(32'd100, 32'd200, 100, 1'b0, "nominal");

        // Divide by zero
        run_measure(32'd0, 32'd77, 1, 1'b0, "divzero");

        // Saturation then a normal run on fresh statistics
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        model_clear();
        run_measure(32'd10, 32'd2560, 4, 1'b0, "saturate");
        run_measure(32'd100, 32'd300, 7, 1'b0, "after_sat");

        // Abort: start while dividing, then complete the new window
        start_run();
        do_done(32'd500, 32'd250, 5);
        model_capture(32'd500, 32'd250);
        repeat (10) tick();
        start = 1'b1;
        tick();
        start  = 1'b0;
        m_snap = 1'b0;
        m_busy = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
        check("abort_no_irq", {31'd0, seen}, 32'd0);
        read_all("abort");
        do_done(32'd700, 32'd1400, 4);
        finish_measure(32'd700, 32'd1400, 1'b0, "abort_second");
        read_all("abort_second");

        // clr_stats landing on the capture edge
        run_measure(32'd250, 32'd999, 6, 1'b1, "clr_settle");

        // Randomised windows
        for (int it = 0; it < 8; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      c = 32'd0;
            else if (sel == 1) c = $urandom;
            else               c = $urandom_range(1, 3000);
            p   = (sel == 2) ? $urandom : $urandom_range(0, 200000);
            clr = ($urandom_range(0, 3) == 0);
            run_measure(c, p, int'($urandom_range(1, 20)), clr, $sformatf("rnd%0d", it));
        end

        // Reset in the middle of a division
        start_run();
        do_done(32'd1000, 32'd3000, 3);
        rd_en   = 1'b1;
        rd_addr = 4'd1;
        repeat (15) tick();
        rst_n = 1'b0;
        rd_en = 1'b0;
        #1;
        check("midrst_rd_data", rd_data, 32'd0);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
        check("midrst_no_irq", {31'd0, seen}, 32'd0);
        model_reset();

        // done outside RUN is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (irq === 1'b1) seen = 1'b1;
        end
        check("idle_done_no_irq", {31'd0, seen}, 32'd0);
        read_all("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
